input_conditioner: RTL and testbench

//  Front-end conditioning for all board buttons and slide switches ahead of the CPU top level.
//  Per channel: two-flop synchronisation to clk, counter-based debounce, registered edge pulses.

---
 rtl/input_conditioner_pkg.sv | 26 ++
 rtl/input_conditioner_debounce_channel.sv | 94 +++++++++
 rtl/input_conditioner.sv | 35 +++
 tb/tb_input_conditioner.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/input_conditioner_pkg.sv
// Shared constants for the board input conditioner: default timing and channel map.
package input_conditioner_pkg;

  localparam int unsigned NUM_CHANNELS            = 10;
  localparam int unsigned DEBOUNCE_CYCLES_DEFAULT = 270000;   // 10 ms at 27 MHz
  localparam int unsigned REPEAT_DELAY_DEFAULT    = 8100000;  // 300 ms at 27 MHz
  localparam int unsigned REPEAT_PERIOD_DEFAULT   = 2700000;  // 100 ms at 27 MHz

  // Channel map so the CPU top level slices level/rise/fall by name
  localparam int unsigned CH_CLK_MODE  = 0;
  localparam int unsigned CH_CLK_PULSE = 1;
  localparam int unsigned CH_RAM_MODE  = 2;
  localparam int unsigned CH_RAM_PULSE = 3;
  localparam int unsigned CH_MAR_SW    = 4;
  localparam int unsigned CH_RAM_SW    = 5;
  localparam int unsigned CH_BOOT_SW   = 6;
  localparam int unsigned CH_BOOT_EN   = 7;
  localparam int unsigned CH_SPARE0    = 8;
  localparam int unsigned CH_SPARE1    = 9;

  // Bits needed to hold values 0..max_val (at least one bit)
  function automatic int unsigned cnt_width(input int unsigned max_val);
    return (max_val < 1) ? 1 : $clog2(max_val + 1);
  endfunction

endpackage

// File: rtl/input_conditioner_debounce_channel.sv
// One conditioner channel: two-flop synchroniser, saturating debounce counter,
// registered level and single-cycle rise/fall strobes.
// Optional feature: define HOLD_REPEAT_EN to emit auto-repeat rise strobes while held.
module debounce_channel
  import input_conditioner_pkg::*;
#(
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
  input  logic clk,
  input  logic rst,
  input  logic i_raw,
  output logic o_level,
  output logic o_rise,
  output logic o_fall
);

  localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  logic             r_s1;
  logic             r_s2;
  logic [CNT_W-1:0] r_cnt;
  logic             r_level;
  logic             r_rise;
  logic             r_fall;
  logic             w_accept;

  // Synchronised input has disagreed with level for the full window
  assign w_accept = (r_s2 != r_level) && (r_cnt == CNT_LAST);

`ifdef HOLD_REPEAT_EN
  localparam int unsigned HOLD_MAX = (REPEAT_DELAY > REPEAT_PERIOD) ? REPEAT_DELAY : REPEAT_PERIOD;
  localparam int unsigned HOLD_W   = cnt_width(HOLD_MAX);

  // Cycles remaining until the next auto-repeat strobe
  logic [HOLD_W-1:0] r_hold;
`else
  logic w_unused_cfg;
  assign w_unused_cfg = ^{REPEAT_DELAY, REPEAT_PERIOD};
`endif

  // Synchroniser, debounce counter, level and strobes (plus repeat countdown when enabled)
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_s1    <= 1'b0;
      r_s2    <= 1'b0;
      r_cnt   <= '0;
      r_level <= 1'b0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
`ifdef HOLD_REPEAT_EN
      r_hold  <= '0;
`endif
    end else begin
      r_s1   <= i_raw;
      r_s2   <= r_s1;
      r_rise <= 1'b0;
      r_fall <= 1'b0;

      if (r_s2 == r_level) begin
        r_cnt <= '0;
      end else if (w_accept) begin
        r_level <= r_s2;
        r_cnt   <= '0;
        r_rise  <= r_s2;
        r_fall  <= ~r_s2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end

`ifdef HOLD_REPEAT_EN
      if (w_accept && r_s2) begin
        r_hold <= HOLD_W'(REPEAT_DELAY - 1);
      end else if (r_level && !w_accept) begin
        if (r_hold == '0) begin
          r_rise <= 1'b1;
          r_hold <= HOLD_W'(REPEAT_PERIOD - 1);
        end else begin
          r_hold <= r_hold - HOLD_W'(1);
        end
      end else begin
        r_hold <= '0;
      end
`endif
    end
  end

  assign o_level = r_level;
  assign o_rise  = r_rise;
  assign o_fall  = r_fall;

endmodule

// File: rtl/input_conditioner.sv
// Board button/switch conditioner: WIDTH independent debounce channels, no shared state.
// Optional feature: define HOLD_REPEAT_EN to enable auto-repeat rise strobes on held inputs.
module input_conditioner
  import input_conditioner_pkg::*;
#(
  parameter int unsigned WIDTH           = NUM_CHANNELS,
  parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEFAULT,
  parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEFAULT
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] raw,
  output logic [WIDTH-1:0] level,
  output logic [WIDTH-1:0] rise,
  output logic [WIDTH-1:0] fall
);

  // One conditioner per pad input
  for (genvar g = 0; g < int'(WIDTH); g++) begin : gen_ch
    debounce_channel #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
      .REPEAT_DELAY    (REPEAT_DELAY),
      .REPEAT_PERIOD   (REPEAT_PERIOD)
    ) u_ch (
      .clk     (clk),
      .rst     (rst),
      .i_raw   (raw[g]),
      .o_level (level[g]),
      .o_rise  (rise[g]),
      .o_fall  (fall[g])
    );
  end

endmodule

// File: tb/tb_input_conditioner.sv
// Bench for input_conditioner: directed scenarios plus random pad activity, checked
// every cycle against a history-based model ("last D synchronised samples disagree").
module tb_input_conditioner;

  localparam int W    = 2;
  localparam int D    = 4;
  localparam int RD   = 10;
  localparam int RP   = 3;
  localparam int MAXC = 4096;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic [W-1:0] raw = '0;
  logic [W-1:0] level, rise, fall;

  always #5 clk = ~clk;

  input_conditioner #(
    .WIDTH           (W),
    .DEBOUNCE_CYCLES (D),
    .REPEAT_DELAY    (RD),
    .REPEAT_PERIOD   (RP)
  ) dut (
    .clk   (clk),
    .rst   (rst),
    .raw   (raw),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  int checks = 0;
  int errors = 0;

  // Model state: raw value sampled at each clock edge, edge count, first edge after reset
  logic [W-1:0] hist [MAXC];
  int           n    = 0;
  int           base = 0;
  logic [W-1:0] m_level = '0;
  logic [W-1:0] exp_rise, exp_fall;
  int           acc_edge       [W];
  int           rise_cnt       [W];
  int           fall_cnt       [W];
  int           last_rise_edge [W];

  // Synchronised sample that came from the raw value of edge i (flops hold 0 after reset)
  function automatic logic samp(input int i, input int c);
    if (i < base || i < 0) return 1'b0;
    return hist[i][c];
  endfunction

  task automatic check(input string tag, input logic [W-1:0] got, input logic [W-1:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%b expected=%b", tag, n, got, exp);
    end
  endtask

  task automatic check_int(input string tag, input int got, input int exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s edge=%0d observed=%0d expected=%0d", tag, n, got, exp);
    end
  endtask

  // Advance one clock, update the model, compare all outputs
  task automatic tick();
    @(posedge clk);
    n++;
    hist[n] = raw;
    exp_rise = '0;
    exp_fall = '0;
    for (int c = 0; c < W; c++) begin
      bit acc;
      acc = 1'b1;
      for (int k = 2; k <= D + 1; k++)
        if (samp(n - k, c) == m_level[c]) acc = 1'b0;
      if (acc) begin
        m_level[c] = ~m_level[c];
        if (m_level[c]) begin
          exp_rise[c] = 1'b1;
          acc_edge[c] = n;
        end else begin
          exp_fall[c] = 1'b1;
        end
      end else if (m_level[c]) begin
`ifdef HOLD_REPEAT_EN
        int h;
        h = n - acc_edge[c];
        if (h == RD || (h > RD && ((h - RD) % RP) == 0)) exp_rise[c] = 1'b1;
`endif
      end
    end
    #1;
    check("level", level, m_level);
    check("rise", rise, exp_rise);
    check("fall", fall, exp_fall);
    check("rise_fall_excl", rise & fall, '0);
    for (int c = 0; c < W; c++) begin
      if (rise[c] === 1'b1) begin
        rise_cnt[c]++;
        last_rise_edge[c] = n;
      end
      if (fall[c] === 1'b1) fall_cnt[c]++;
    end
  endtask

  task automatic ticks(input int k);
    for (int i = 0; i < k; i++) tick();
  endtask

  // Asynchronous reset: outputs must clear before any clock edge
  task automatic do_reset();
    rst = 1'b1;
    #1;
    check("reset_level", level, '0);
    check("reset_rise", rise, '0);
    check("reset_fall", fall, '0);
    m_level = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    base = n + 1;
  endtask

  initial begin
    int t0, rc0, fc0, rc1, a_edge;
    bit seen, seen_bad;

    for (int c = 0; c < W; c++) begin
      acc_edge[c] = 0; rise_cnt[c] = 0; fall_cnt[c] = 0; last_rise_edge[c] = -1;
    end
    #2;
    do_reset();
    ticks(3);

    // 1: clean 0->1 on channel 0
    t0 = n; rc0 = rise_cnt[0]; fc0 = fall_cnt[0];
    raw = 2'b01;
    ticks(10);
    check_int("t1_rise_latency", last_rise_edge[0] - t0, 6);
    check_int("t1_rise_count", rise_cnt[0] - rc0, 1);
    check_int("t1_no_fall", fall_cnt[0] - fc0, 0);

    // 2: bounce then settle high
    raw = 2'b00; ticks(10);
    rc0 = rise_cnt[0];
    raw = 2'b01; tick(); raw = 2'b00; tick(); raw = 2'b01; tick(); raw = 2'b00; tick();
    raw = 2'b01; t0 = n;
    ticks(9);
    check_int("t2_rise_after_bounce", last_rise_edge[0] - t0, 6);
    check_int("t2_single_rise", rise_cnt[0] - rc0, 1);

    // 3: short low glitch while high is rejected
    fc0 = fall_cnt[0]; rc0 = rise_cnt[0];
    raw = 2'b00; ticks(3);
    raw = 2'b01; ticks(8);
    check("t3_level_held", level, 2'b01);
    check_int("t3_no_fall", fall_cnt[0] - fc0, 0);
    check_int("t3_no_rise", rise_cnt[0] - rc0, 0);

    // 4: simultaneous channels
    raw = 2'b00; ticks(10);
    raw = 2'b11; seen = 1'b0;
    for (int i = 0; i < 8; i++) begin tick(); if (rise === 2'b11) seen = 1'b1; end
    check_int("t4_joint_rise", int'(seen), 1);
    raw = 2'b01; seen = 1'b0; seen_bad = 1'b0;
    for (int i = 0; i < 8; i++) begin
      tick();
      if (fall === 2'b10) seen = 1'b1;
      if (fall[0] === 1'b1) seen_bad = 1'b1;
    end
    check_int("t4_fall_ch1_only", int'(seen), 1);
    check_int("t4_no_fall_ch0", int'(seen_bad), 0);

    // 5: reset in the middle of channel 1's window
    raw = 2'b11; ticks(4);
    do_reset();
    t0 = n; rc0 = rise_cnt[0]; rc1 = rise_cnt[1];
    ticks(9);
    check_int("t5_rise0_after_rst", last_rise_edge[0] - t0, 6);
    check_int("t5_rise1_after_rst", last_rise_edge[1] - t0, 6);
    check_int("t5_rise1_once", rise_cnt[1] - rc1, 1);

    // 6: hold channel 0 high (auto-repeat when enabled)
    raw = 2'b00; ticks(10);
    raw = 2'b01; seen = 1'b0;
    for (int i = 0; i < 20 && !seen; i++) begin tick(); if (rise[0] === 1'b1) seen = 1'b1; end
    check_int("t6_first_rise_seen", int'(seen), 1);
    a_edge = n; rc0 = rise_cnt[0];
    ticks(18);
`ifdef HOLD_REPEAT_EN
    check_int("t6_repeats", rise_cnt[0] - rc0, 3);
    check_int("t6_last_repeat", last_rise_edge[0] - a_edge, 16);
`else
    check_int("t6_repeats", rise_cnt[0] - rc0, 0);
`endif
    raw = 2'b00; ticks(12);
    rc0 = rise_cnt[0];
    ticks(20);
    check_int("t6_stop_after_fall", rise_cnt[0] - rc0, 0);

    // Random pad activity with occasional resets
    for (int i = 0; i < 900; i++) begin
      for (int c = 0; c < W; c++)
        if ($urandom_range(0, 9) == 0) raw[c] = ~raw[c];
      if ($urandom_range(0, 249) == 0) do_reset();
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
